// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store MEM stage: op codes, exception causes,
// LSU states, the captured request record and lane helper functions.
package lsu_mem_stage_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned CAUSE_W = 2;
    localparam int unsigned XLEN    = 32;

    typedef enum logic [OP_W-1:0] {
        DMEM_NO  = 4'd0,
        DMEM_LB  = 4'd1,
        DMEM_LH  = 4'd2,
        DMEM_LW  = 4'd3,
        DMEM_LBU = 4'd4,
        DMEM_LHU = 4'd5,
        DMEM_SB  = 4'd6,
        DMEM_SH  = 4'd7,
        DMEM_SW  = 4'd8
    } dmem_type_e;

    typedef enum logic [CAUSE_W-1:0] {
        EXC_LD_MISALIGN  = 2'd0,
        EXC_ST_MISALIGN  = 2'd1,
        EXC_ACCESS_FAULT = 2'd2
    } exc_cause_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] addr;
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == DMEM_SB) || (op == DMEM_SH) || (op == DMEM_SW);
    endfunction

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == DMEM_LB) || (op == DMEM_LH) || (op == DMEM_LW) ||
               (op == DMEM_LBU) || (op == DMEM_LHU) || is_store(op);
    endfunction

    function automatic logic is_misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if ((op == DMEM_LH) || (op == DMEM_LHU) || (op == DMEM_SH)) mis = off[0];
        if ((op == DMEM_LW) || (op == DMEM_SW))                     mis = (off != 2'd0);
        return mis;
    endfunction

    function automatic logic [3:0] lane_be(input logic [OP_W-1:0] op, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        if (op == DMEM_SB) be = 4'b0001 << off;
        if (op == DMEM_SH) be = 4'b0011 << off;
        return be;
    endfunction

    // Store data replicated across lanes so the byte enables alone pick the target.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [OP_W-1:0] op, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] r;
        r = '0;
        if (op == DMEM_SB) r = {4{wd[7:0]}};
        if (op == DMEM_SH) r = {2{wd[15:0]}};
        if (op == DMEM_SW) r = wd;
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// Combinational load extractor: selects byte/half from the raw word by byte
// offset and sign- or zero-extends it; stores and NO op yield zero.
module lsu_load_align
    import lsu_mem_stage_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    always_comb begin
        half   = 16'(raw >> {offset, 3'b000});
        byte_v = half[7:0];
        data   = '0;
        case (op)
            DMEM_LB:  data = {{24{byte_v[7]}}, byte_v};
            DMEM_LBU: data = {24'd0, byte_v};
            DMEM_LH:  data = {{16{half[15]}}, half};
            DMEM_LHU: data = {16'd0, half};
            DMEM_LW:  data = raw;
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage with a valid/ready data-memory request channel and a separate
// response channel; stalls upstream while an access is in flight.
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int unsigned DMEM_AW = 10,
    parameter int unsigned WB_W    = 64,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               valid_e_i,
    input  logic [OP_W-1:0]    dmem_type_e_i,
    input  logic [XLEN-1:0]    addr_e_i,
    input  logic [XLEN-1:0]    wdata_e_i,
    input  logic [WB_W-1:0]    wb_payload_e_i,
    output logic               stall_o,
    output logic               req_valid_o,
    input  logic               req_ready_i,
    output logic               req_we_o,
    output logic [DMEM_AW-1:0] req_addr_o,
    output logic [3:0]         req_be_o,
    output logic [XLEN-1:0]    req_wdata_o,
    input  logic               rsp_valid_i,
    input  logic [XLEN-1:0]    rsp_rdata_i,
    input  logic               rsp_err_i,
    output logic               valid_m_o,
    output logic [XLEN-1:0]    load_data_m_o,
    output logic [WB_W-1:0]    wb_payload_m_o,
    output logic               exc_valid_m_o,
    output logic [CAUSE_W-1:0] exc_cause_m_o,
    output logic [XLEN-1:0]    exc_addr_m_o
);

    lsu_state_e      state, state_nxt;
    lsu_req_t        req_q;
    logic [WB_W-1:0] payload_q;
    logic [TO_W-1:0] cnt_q;
    logic [XLEN-1:0] align_data;

    logic e_mem, e_mis, accept, timed_out, complete, fault;

    assign e_mem     = valid_e_i && is_mem_op(dmem_type_e_i);
    assign e_mis     = is_misaligned(dmem_type_e_i, addr_e_i[1:0]);
    assign accept    = (state == LSU_IDLE) && e_mem && !e_mis;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT));
    assign complete  = (state == LSU_WAIT) && (rsp_valid_i || timed_out);
    // A real response always wins over a coincident timeout.
    assign fault     = rsp_valid_i ? rsp_err_i : 1'b1;

    assign req_we_o    = is_store(req_q.op);
    assign req_addr_o  = req_q.addr[DMEM_AW+1:2];
    assign req_be_o    = req_q.be;
    assign req_wdata_o = req_q.wdata;

    lsu_load_align u_align (
        .op     (req_q.op),
        .offset (req_q.addr[1:0]),
        .raw    (rsp_rdata_i),
        .data   (align_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= LSU_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (accept)      state_nxt = LSU_REQ;
            LSU_REQ:  if (req_ready_i) state_nxt = LSU_WAIT;
            LSU_WAIT: if (complete)    state_nxt = LSU_IDLE;
            default:                   state_nxt = LSU_IDLE;
        endcase
    end

    always_comb begin
        stall_o     = 1'b0;
        req_valid_o = 1'b0;
        case (state)
            LSU_IDLE: stall_o = accept;
            LSU_REQ: begin
                stall_o     = 1'b1;
                req_valid_o = 1'b1;
            end
            LSU_WAIT: stall_o = !complete;
            default:  stall_o = 1'b0;
        endcase
    end

    // Request capture, timeout counter and WB-side result registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_q          <= '0;
            payload_q      <= '0;
            cnt_q          <= '0;
            valid_m_o      <= 1'b0;
            load_data_m_o  <= '0;
            wb_payload_m_o <= '0;
            exc_valid_m_o  <= 1'b0;
            exc_cause_m_o  <= '0;
            exc_addr_m_o   <= '0;
        end else begin
            valid_m_o     <= 1'b0;
            exc_valid_m_o <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (valid_e_i && !e_mem) begin
                        valid_m_o      <= 1'b1;
                        wb_payload_m_o <= wb_payload_e_i;
                        load_data_m_o  <= '0;
                    end else if (e_mem && e_mis) begin
                        valid_m_o      <= 1'b1;
                        wb_payload_m_o <= wb_payload_e_i;
                        load_data_m_o  <= '0;
                        exc_valid_m_o  <= 1'b1;
                        exc_cause_m_o  <= is_store(dmem_type_e_i) ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                        exc_addr_m_o   <= addr_e_i;
                    end else if (accept) begin
                        req_q <= '{op:    dmem_type_e_i,
                                   addr:  addr_e_i,
                                   be:    lane_be(dmem_type_e_i, addr_e_i[1:0]),
                                   wdata: lane_wdata(dmem_type_e_i, wdata_e_i)};
                        payload_q <= wb_payload_e_i;
                    end
                end
                LSU_REQ: cnt_q <= '0;
                LSU_WAIT: begin
                    cnt_q <= cnt_q + TO_W'(1);
                    if (complete) begin
                        valid_m_o      <= 1'b1;
                        wb_payload_m_o <= payload_q;
                        if (fault) begin
                            load_data_m_o <= '0;
                            exc_valid_m_o <= 1'b1;
                            exc_cause_m_o <= EXC_ACCESS_FAULT;
                            exc_addr_m_o  <= req_q.addr;
                        end else begin
                            load_data_m_o <= align_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage with a short timeout (4).
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned WW = 64;
    localparam int unsigned TO = 4;
    localparam int unsigned TW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          valid_e;
    logic [3:0]    dmem_type_e;
    logic [31:0]   addr_e;
    logic [31:0]   wdata_e;
    logic [WW-1:0] payload_e;
    logic          stall;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          valid_m;
    logic [31:0]   load_data_m;
    logic [WW-1:0] payload_m;
    logic          exc_valid_m;
    logic [1:0]    exc_cause_m;
    logic [31:0]   exc_addr_m;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.DMEM_AW(AW), .WB_W(WW), .TIMEOUT(TO), .TO_W(TW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .valid_e_i      (valid_e),
        .dmem_type_e_i  (dmem_type_e),
        .addr_e_i       (addr_e),
        .wdata_e_i      (wdata_e),
        .wb_payload_e_i (payload_e),
        .stall_o        (stall),
        .req_valid_o    (req_valid),
        .req_ready_i    (req_ready),
        .req_we_o       (req_we),
        .req_addr_o     (req_addr),
        .req_be_o       (req_be),
        .req_wdata_o    (req_wdata),
        .rsp_valid_i    (rsp_valid),
        .rsp_rdata_i    (rsp_rdata),
        .rsp_err_i      (rsp_err),
        .valid_m_o      (valid_m),
        .load_data_m_o  (load_data_m),
        .wb_payload_m_o (payload_m),
        .exc_valid_m_o  (exc_valid_m),
        .exc_cause_m_o  (exc_cause_m),
        .exc_addr_m_o   (exc_addr_m)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One aligned access: ready after rdy_dly REQ cycles, response (or none) in WAIT cycle rsp_dly.
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int rdy_dly, input int rsp_dly, input logic give_rsp,
                          input logic err, input logic [31:0] rdata,
                          input logic [3:0] xbe, input logic [31:0] xwd,
                          input logic [31:0] xload, input logic xexc);
        logic [63:0] pl;
        logic        xwe;
        pl  = {32'hC0DE_0000, addr};
        xwe = (op == DMEM_SB) || (op == DMEM_SH) || (op == DMEM_SW);
        valid_e = 1'b1; dmem_type_e = op; addr_e = addr; wdata_e = wd; payload_e = pl;
        #1;
        chk("accept_stall", 64'(stall), 64'd1);
        tick;
        for (int i = 0; i <= rdy_dly; i++) begin
            req_ready = (i == rdy_dly);
            #1;
            chk("req_valid", 64'(req_valid), 64'd1);
            chk("req_addr", 64'(req_addr), 64'(addr[11:2]));
            chk("req_we", 64'(req_we), 64'(xwe));
            chk("req_be", 64'(req_be), 64'(xbe));
            if (xwe) chk("req_wdata", 64'(req_wdata), 64'(xwd));
            chk("req_stall", 64'(stall), 64'd1);
            tick;
        end
        req_ready = 1'b0;
        for (int i = 0; i <= rsp_dly; i++) begin
            rsp_valid = (i == rsp_dly) && give_rsp;
            rsp_err   = err;
            rsp_rdata = rdata;
            #1;
            chk("wait_stall", 64'(stall), 64'(i != rsp_dly));
            chk("wait_req_valid", 64'(req_valid), 64'd0);
            chk("wait_valid_m", 64'(valid_m), 64'd0);
            tick;
        end
        rsp_valid = 1'b0; rsp_err = 1'b0; valid_e = 1'b0;
        chk("done_valid_m", 64'(valid_m), 64'd1);
        chk("done_load", 64'(load_data_m), 64'(xload));
        chk("done_exc", 64'(exc_valid_m), 64'(xexc));
        chk("done_payload", payload_m, pl);
        if (xexc) begin
            chk("done_cause", 64'(exc_cause_m), 64'd2);
            chk("done_exc_addr", 64'(exc_addr_m), 64'(addr));
        end
        tick;
        chk("pulse_end", 64'(valid_m), 64'd0);
    endtask

    task automatic misaligned(input logic [3:0] op, input logic [31:0] addr, input logic [1:0] xcause);
        valid_e = 1'b1; dmem_type_e = op; addr_e = addr; wdata_e = 32'h5555_5555;
        payload_e = 64'hBAD0_0000_0000_0000 | 64'(addr);
        #1;
        chk("mis_stall", 64'(stall), 64'd0);
        chk("mis_req_valid", 64'(req_valid), 64'd0);
        tick;
        valid_e = 1'b0;
        #1;
        chk("mis_valid_m", 64'(valid_m), 64'd1);
        chk("mis_exc", 64'(exc_valid_m), 64'd1);
        chk("mis_cause", 64'(exc_cause_m), 64'(xcause));
        chk("mis_addr", 64'(exc_addr_m), 64'(addr));
        chk("mis_no_req", 64'(req_valid), 64'd0);
        chk("mis_stall_after", 64'(stall), 64'd0);
        tick;
        chk("mis_pulse_end", 64'(valid_m), 64'd0);
    endtask

    initial begin
        resetn = 1'b0; valid_e = 1'b0; dmem_type_e = DMEM_NO; addr_e = '0; wdata_e = '0;
        payload_e = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        tick; tick;
        chk("rst_valid_m", 64'(valid_m), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_exc", 64'(exc_valid_m), 64'd0);
        chk("rst_load", 64'(load_data_m), 64'd0);
        resetn = 1'b1;
        tick;

        access(DMEM_LW,  32'h104, 32'h0, 0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access(DMEM_LB,  32'h103, 32'h0, 0, 0, 1'b1, 1'b0, 32'h80FF_7F01, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b0);
        access(DMEM_LBU, 32'h102, 32'h0, 0, 1, 1'b1, 1'b0, 32'h80FF_7F01, 4'hF, 32'h0, 32'h0000_00FF, 1'b0);
        access(DMEM_LH,  32'h102, 32'h0, 1, 0, 1'b1, 1'b0, 32'h80FF_7F01, 4'hF, 32'h0, 32'hFFFF_80FF, 1'b0);
        access(DMEM_LHU, 32'h100, 32'h0, 0, 2, 1'b1, 1'b0, 32'h80FF_7F01, 4'hF, 32'h0, 32'h0000_7F01, 1'b0);
        access(DMEM_SB,  32'h203, 32'hFFFF_FFA5, 0, 0, 1'b1, 1'b0, 32'h1234_5678, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
        access(DMEM_SH,  32'h202, 32'hFFFF_1234, 0, 1, 1'b1, 1'b0, 32'h1234_5678, 4'b1100, 32'h1234_1234, 32'h0, 1'b0);

        misaligned(DMEM_SW, 32'h206, 2'd1);
        misaligned(DMEM_LH, 32'h101, 2'd0);

        // Ready held low for 5 cycles, then a bus-error response.
        access(DMEM_LW, 32'h300, 32'h0, 5, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 1'b1);
        // No response at all: completes when the WAIT counter reaches 4.
        access(DMEM_LW, 32'h304, 32'h0, 0, 4, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b1);

        // Back-to-back NO ops.
        valid_e = 1'b1; dmem_type_e = DMEM_NO; payload_e = 64'h1111_2222_3333_4444;
        #1;
        chk("no_stall", 64'(stall), 64'd0);
        tick;
        payload_e = 64'h5555_6666_7777_8888;
        chk("no1_valid_m", 64'(valid_m), 64'd1);
        chk("no1_payload", payload_m, 64'h1111_2222_3333_4444);
        chk("no1_load", 64'(load_data_m), 64'd0);
        tick;
        valid_e = 1'b0;
        chk("no2_valid_m", 64'(valid_m), 64'd1);
        chk("no2_payload", payload_m, 64'h5555_6666_7777_8888);
        tick;
        chk("no_idle_valid_m", 64'(valid_m), 64'd0);

        // Reset while in WAIT abandons the access.
        valid_e = 1'b1; dmem_type_e = DMEM_LW; addr_e = 32'h400; payload_e = 64'h99;
        tick;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0; valid_e = 1'b0;
        #1;
        chk("wait_before_rst_stall", 64'(stall), 64'd1);
        resetn = 1'b0;
        tick;
        chk("rstw_req_valid", 64'(req_valid), 64'd0);
        chk("rstw_valid_m", 64'(valid_m), 64'd0);
        chk("rstw_stall", 64'(stall), 64'd0);
        resetn = 1'b1;
        tick;
        access(DMEM_LW, 32'h404, 32'h0, 0, 0, 1'b1, 1'b0, 32'h1122_3344, 4'hF, 32'h0, 32'h1122_3344, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Parametrised successor to the fixed 1-cycle MEM stage with load/store.
- Talks to data memory over a valid/ready request channel and a separate response channel, so memory latency can vary.
- Stalls upstream while an access is in flight.
- Detects misaligned accesses, bus errors and timeouts, and reports them as exceptions.
- Passes a generic write-back payload through to the WB stage.

Parameters:
- DMEM_AW, 10: word-address width presented to data memory.
- WB_W, 64: width of the opaque WB payload (rd_idx, reg_write_en, result_src, imm, pc_plus, ...) carried alongside.
- TIMEOUT, 255: maximum number of WAIT cycles before an access fault; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- valid_e_i  in  1  EXE-stage instruction valid
- dmem_type_e_i  in  4  `DMEM_* op code (NO/LB/LH/LW/LBU/LHU/SB/SH/SW)
- addr_e_i  in  32  byte address (ALU result)
- wdata_e_i  in  32  store data
- wb_payload_e_i  in  WB_W  passthrough payload
- stall_o  out  1  upstream hold request (combinational)
- req_valid_o  out  1  memory request valid
- req_ready_i  in  1  memory accepts request
- req_we_o  out  1  1 = store
- req_addr_o  out  DMEM_AW  word address, addr[DMEM_AW+1:2]
- req_be_o  out  4  byte enables
- req_wdata_o  out  32  lane-aligned store data
- rsp_valid_i  in  1  response valid (loads and stores)
- rsp_rdata_i  in  32  raw word read
- rsp_err_i  in  1  bus error, qualified by rsp_valid_i
- valid_m_o  out  1  result valid to WB
- load_data_m_o  out  32  aligned, extended load data
- wb_payload_m_o  out  WB_W  registered payload
- exc_valid_m_o  out  1  exception with this result
- exc_cause_m_o  out  2  `EXC_LD_MISALIGN / `EXC_ST_MISALIGN / `EXC_ACCESS_FAULT
- exc_addr_m_o  out  32  faulting byte address

Behaviour:
- Reset: all outputs 0 and state IDLE; any in-flight access is abandoned. The memory shares resetn, so no stale response can arrive after reset.
- Misalignment rules:
  - LH/LHU/SH are misaligned when addr[0]=1.
  - LW/SW are misaligned when addr[1:0]!=0.
  - Byte ops are never misaligned.
- States and transitions:
  - IDLE, valid_e_i & NO op: 1-cycle passthrough. Next edge: valid_m_o=1, payload registered, load_data=0, stall_o=0.
  - IDLE, valid memory op, misaligned: no request issued, stall_o=0. Next edge: valid_m_o=1, exc_valid=1, cause LD/ST_MISALIGN, exc_addr=addr.
  - IDLE, valid memory op, aligned: stall_o=1 in the same cycle. At the edge, op, addr[1:0], address, be, wdata and payload are captured; go to REQ.
  - IDLE, valid_e_i=0: next edge valid_m_o=0.
  - REQ: req_valid_o=1 with stable fields until req_ready_i; at the handshake edge go to WAIT. stall_o=1.
  - WAIT: counter increments each cycle; stall_o=1 except in the completion cycle.
    - Memory must not assert rsp_valid_i in the handshake cycle; rsp_valid_i is sampled only in WAIT.
    - Completion occurs when rsp_valid_i, or when TIMEOUT!=0 and counter==TIMEOUT.
    - In the completion cycle stall_o=0, so upstream advances at that edge.
    - At that edge valid_m_o=1 and the next state is IDLE. An instruction still present on the E inputs in that cycle is not re-accepted.
    - On rsp_err_i or timeout: exc_valid=1, cause ACCESS_FAULT, load_data=0.
    - If rsp_valid_i and timeout coincide, the response wins.
- valid_m_o is a single-cycle pulse per instruction; it is 0 while stalled.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{b}}.
  - SH: be=0011<<addr[1:0], wdata={2{h}}.
  - SW: be=1111.
  - Loads: be=1111, we=0.
- Load extract uses captured addr[1:0]: sign-extend for LB/LH, zero-extend for LBU/LHU, whole word for LW. Stores return load_data=0.
- Store completion still requires rsp_valid_i, used as a write acknowledge.
- Throughput: one non-memory op per cycle. Memory ops occupy 2+L cycles, where L is the response latency.

Decomposition:
- Shared definitions.vh holds:
  - `DMEM_* codes (existing).
  - New `EXC_LD_MISALIGN=2'd0, `EXC_ST_MISALIGN=2'd1, `EXC_ACCESS_FAULT=2'd2.
  - LSU state encodings IDLE/REQ/WAIT.
- One combinational sub-module, lsu_load_align (op, byte offset, raw word -> extended data), reused by the bypass path.

Test Plan:
- LW at 0x104, memory holds 0xDEADBEEF, ready immediate, rsp after 1 cycle -> stall_o high 2 cycles; valid_m_o one pulse; load_data 0xDEADBEEF; no exception.
- Word holds 0x80FF7F01: LB addr[1:0]=3 -> 0xFFFFFF80; LBU offset 2 -> 0x000000FF; LH offset 2 -> 0xFFFF80FF; LHU offset 0 -> 0x00007F01.
- SB 0xA5 at 0x203 -> be=1000, wdata=0xA5A5A5A5. SH 0x1234 at 0x202 -> be=1100. SW at 0x206 -> no req_valid_o; exc cause ST_MISALIGN, exc_addr 0x206, stall_o never high.
- req_ready_i held low 5 cycles -> req fields stable throughout; rsp_err_i on the response -> ACCESS_FAULT, load_data 0.
- TIMEOUT=4, no response -> completion exactly 4 cycles after entering WAIT with ACCESS_FAULT. Back-to-back NO ops then produce valid_m_o on consecutive cycles.
- resetn low while in WAIT -> next cycle IDLE, req_valid_o/valid_m_o/stall_o=0. A fresh LW afterwards completes normally.
